// File: rtl/cv_pad_if.sv
// cv_pad_if: PS/2, joystick and strobe inputs plus console pin outputs for cv_pad_encoder
interface cv_pad_if #(parameter int NUM_PORTS = 2);
  logic [65:0] ps2_key;
  logic [16*NUM_PORTS-1:0] joy;
  logic [NUM_PORTS-1:0] sel_kp_n;
  logic [NUM_PORTS-1:0] sel_joy_n;
  logic [NUM_PORTS-1:0] autofire_en;
  logic [4*NUM_PORTS-1:0] ctrl_d;
  logic [NUM_PORTS-1:0] ctrl_p6;
  modport master (output ps2_key, joy, sel_kp_n, sel_joy_n, autofire_en, input ctrl_d, ctrl_p6);
  modport slave (input ps2_key, joy, sel_kp_n, sel_joy_n, autofire_en, output ctrl_d, ctrl_p6);
endinterface

// File: rtl/cv_pad_encoder.sv
// cv_pad_encoder: ColecoVision controller encoder merging PS/2 keyboard and joysticks; CV_PAD_AUTOFIRE_EN adds autofire
module cv_pad_encoder #(
  parameter int NUM_PORTS = 2,
  parameter int KBD_PORT = 0,
  parameter int AF_HALF = 357954
) (
  input logic clk_sys,
  input logic reset,
  cv_pad_if.slave bus
);
  localparam logic [3:0] NONE = 4'hF;
  function automatic logic [3:0] lowest(input logic [13:0] v);
    lowest = NONE;
    for (int i = 13; i >= 0; i--) if (v[i]) lowest = 4'(i);
  endfunction
  function automatic logic [3:0] code(input logic [3:0] k);
    case (k)
      4'd0: code = 4'b0011;
      4'd1: code = 4'b1110;
      4'd2: code = 4'b1101;
      4'd3: code = 4'b0110;
      4'd4: code = 4'b0001;
      4'd5: code = 4'b1001;
      4'd6: code = 4'b0111;
      4'd7: code = 4'b1100;
      4'd8: code = 4'b1000;
      4'd9: code = 4'b1011;
      4'd10: code = 4'b1010;
      4'd11: code = 4'b0101;
      4'd12: code = 4'b0100;
      4'd13: code = 4'b0010;
      default: code = 4'b1111;
    endcase
  endfunction
  logic tog_q;
  logic [13:0] kb_kp;
  logic [5:0] kb_ctl;
  logic [7:0] sc;
  logic pressed, ext, evt, hit_kp, hit_ctl;
  logic [3:0] kp_idx;
  logic [2:0] ctl_idx;
  logic unused_ps2;
  assign unused_ps2 = bus.ps2_key[65];
  assign evt = bus.ps2_key[64] != tog_q;
  assign sc = |bus.ps2_key[63:24] ? 8'h00 : bus.ps2_key[7:0];
  assign pressed = bus.ps2_key[15:8] != 8'hF0;
  assign ext = bus.ps2_key[23:16] == 8'hE0 || bus.ps2_key[15:8] == 8'hE0;
  always_comb begin
    hit_kp = 1'b1;
    kp_idx = 4'd0;
    case (sc)
      8'h45, 8'h22: kp_idx = 4'd0;
      8'h16: kp_idx = 4'd1;
      8'h1E: kp_idx = 4'd2;
      8'h26: kp_idx = 4'd3;
      8'h25, 8'h15: kp_idx = 4'd4;
      8'h2E, 8'h1D: kp_idx = 4'd5;
      8'h36, 8'h24: kp_idx = 4'd6;
      8'h3D, 8'h1C: kp_idx = 4'd7;
      8'h3E, 8'h1B: kp_idx = 4'd8;
      8'h46, 8'h23: kp_idx = 4'd9;
      8'h1A: kp_idx = 4'd10;
      8'h21: kp_idx = 4'd11;
      8'h1F, 8'h27: kp_idx = 4'd12;
      8'h11: kp_idx = 4'd13;
      default: hit_kp = 1'b0;
    endcase
    hit_ctl = 1'b1;
    ctl_idx = 3'd0;
    case (sc)
      8'h74: ctl_idx = 3'd0;
      8'h6B: ctl_idx = 3'd1;
      8'h72: ctl_idx = 3'd2;
      8'h75: ctl_idx = 3'd3;
      8'h14: ctl_idx = 3'd4;
      8'h12, 8'h59: begin
        ctl_idx = 3'd5;
        hit_ctl = !ext;
      end
      default: hit_ctl = 1'b0;
    endcase
  end
  // The toggle copy tracks the input even in reset so a stale word is not replayed afterwards
  always_ff @(posedge clk_sys) begin
    tog_q <= bus.ps2_key[64];
    if (reset) begin
      kb_kp <= '0;
      kb_ctl <= '0;
    end else begin
      if (evt && hit_kp) kb_kp[kp_idx] <= pressed;
      if (evt && hit_ctl) kb_ctl[ctl_idx] <= pressed;
    end
  end
  logic [NUM_PORTS-1:0] af_gate;
`ifdef CV_PAD_AUTOFIRE_EN
  localparam int CW = AF_HALF > 1 ? $clog2(AF_HALF) : 1;
  logic [CW-1:0] af_cnt;
  logic af_ph;
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      af_cnt <= '0;
      af_ph <= 1'b1;
    end else if (af_cnt == CW'(AF_HALF - 1)) begin
      af_cnt <= '0;
      af_ph <= ~af_ph;
    end else af_cnt <= af_cnt + 1'b1;
  end
  assign af_gate = ~bus.autofire_en | {NUM_PORTS{af_ph}};
`else
  logic unused_af;
  assign unused_af = ^bus.autofire_en;
  assign af_gate = '1;
`endif
  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    logic [15:0] j;
    logic [13:0] kp, prev, rise;
    logic [15:0] kpx;
    logic [5:0] ctl;
    logic [3:0] lat_q, lat_d, kp_o, js_o, d_q;
    logic p6_q, unused_hi;
    assign j = bus.joy[16*p +: 16];
    assign unused_hi = ^j[15:14];
    assign kp = {j[13], j[12], j[7], j[6], 6'b0, j[11:8]} | (p == KBD_PORT ? kb_kp : 14'b0);
    assign ctl = j[5:0] | (p == KBD_PORT ? kb_ctl : 6'b0);
    assign rise = kp & ~prev;
    assign kpx = {2'b0, kp};
    // Newest press wins; on release of the latched key fall back to the lowest still held
    assign lat_d = |rise ? lowest(rise) : (lat_q != NONE && !kpx[lat_q]) ? lowest(kp) : lat_q;
    assign kp_o = bus.sel_kp_n[p] ? 4'hF : code(lat_d);
    assign js_o = bus.sel_joy_n[p] ? 4'hF : ~ctl[3:0];
    always_ff @(posedge clk_sys) begin
      if (reset) begin
        prev <= '0;
        lat_q <= NONE;
        d_q <= 4'hF;
        p6_q <= 1'b1;
      end else begin
        prev <= kp;
        lat_q <= lat_d;
        d_q <= kp_o & js_o;
        p6_q <= (bus.sel_kp_n[p] | ~ctl[5]) & (bus.sel_joy_n[p] | ~(ctl[4] & af_gate[p]));
      end
    end
    assign bus.ctrl_d[4*p +: 4] = d_q;
    assign bus.ctrl_p6[p] = p6_q;
  end
endmodule

// File: tb/tb_cv_pad_encoder.sv
// tb_cv_pad_encoder: scoreboard bench for cv_pad_encoder (2 ports, AF_HALF=4)
module tb_cv_pad_encoder;
  typedef struct {
    int due;
    int port;
    logic [3:0] d;
    logic p6;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tog = 1'b0;
  int cyc = 0;
  int ne = 0;
  int n_chk = 0;
  int n_bad = 0;
  exp_t q[$];
  string tq[$];
  exp_t e;
  string t;
  cv_pad_if #(.NUM_PORTS(2)) bus ();
  cv_pad_encoder #(.NUM_PORTS(2), .KBD_PORT(0), .AF_HALF(4)) dut (.clk_sys(clk), .reset(rst), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    ne <= rst ? 0 : ne + 1;
  end
  task automatic chk(input string tag, input logic [4:0] got, input logic [4:0] want);
    n_chk++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %b want %b", tag, got, want);
    end
  endtask
  always @(negedge clk)
    while (q.size() > 0 && q[0].due <= cyc) begin
      e = q.pop_front();
      t = tq.pop_front();
      chk(t, {bus.ctrl_d[4*e.port +: 4], bus.ctrl_p6[e.port]}, {e.d, e.p6});
    end
  task automatic ex(input string tag, input int lat, input int port, input logic [3:0] d, input logic p6);
    q.push_back('{cyc + lat, port, d, p6});
    tq.push_back(tag);
  endtask
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic ps2(input logic [7:0] b15, input logic [7:0] c, input logic [7:0] b23 = 8'h00, input logic [39:0] hi = 40'h0);
    tog = ~tog;
    bus.ps2_key = {1'b0, tog, hi, b23, b15, c};
  endtask
  initial begin
    bus.ps2_key = '0;
    bus.joy = '0;
    bus.sel_kp_n = 2'b11;
    bus.sel_joy_n = 2'b11;
    bus.autofire_en = 2'b00;
    step(3);
    ex("rst_p0", 0, 0, 4'hF, 1'b1);
    ex("rst_p1", 0, 1, 4'hF, 1'b1);
    rst = 1'b0;
    step(1);
    ex("idle_p0", 0, 0, 4'hF, 1'b1);
    // keyboard keypad on port 0
    bus.sel_kp_n = 2'b10;
    ps2(8'h00, 8'h16);
    ex("kb1", 2, 0, 4'b1110, 1'b1);
    ex("kb1_p1", 2, 1, 4'hF, 1'b1);
    step(3);
    ps2(8'hF0, 8'h16);
    ex("kb1_rel", 2, 0, 4'hF, 1'b1);
    step(3);
    bus.joy[9] = 1'b1;
    ex("joy1", 1, 0, 4'b1110, 1'b1);
    step(2);
    ps2(8'h00, 8'h45);
    ex("x_over1", 2, 0, 4'b0011, 1'b1);
    step(3);
    ps2(8'hF0, 8'h45);
    ex("back1", 2, 0, 4'b1110, 1'b1);
    step(3);
    bus.joy = '0;
    ex("all_rel", 1, 0, 4'hF, 1'b1);
    step(2);
    ps2(8'h00, 8'h45);
    ex("kb0", 2, 0, 4'b0011, 1'b1);
    step(3);
    bus.joy[11] = 1'b1;
    ex("last_wins3", 1, 0, 4'b0110, 1'b1);
    step(2);
    bus.joy[11] = 1'b0;
    ex("fallback0", 1, 0, 4'b0011, 1'b1);
    step(2);
    ps2(8'hF0, 8'h45);
    ex("rel0", 2, 0, 4'hF, 1'b1);
    step(3);
    ps2(8'h00, 8'h15);
    ex("q_key4", 2, 0, 4'b0001, 1'b1);
    step(3);
    ps2(8'hF0, 8'h15);
    step(3);
    ps2(8'h00, 8'h1A);
    ex("z_star", 2, 0, 4'b1010, 1'b1);
    step(3);
    ps2(8'hF0, 8'h1A);
    ex("z_rel", 2, 0, 4'hF, 1'b1);
    step(3);
    // joystick on port 1
    bus.sel_kp_n = 2'b11;
    bus.sel_joy_n = 2'b01;
    bus.joy[31:16] = 16'h0009;
    ex("js_ur", 1, 1, 4'b0110, 1'b1);
    ex("js_p0_off", 1, 0, 4'hF, 1'b1);
    step(2);
    bus.joy[31:16] = 16'h0019;
    ex("js_fire1", 1, 1, 4'b0110, 1'b0);
    step(2);
    bus.joy = '0;
    ex("js_rel", 1, 1, 4'hF, 1'b1);
    step(2);
    // both strobes low on port 0
    bus.sel_kp_n = 2'b10;
    bus.sel_joy_n = 2'b10;
    ps2(8'h00, 8'h3E);
    bus.joy[1] = 1'b1;
    ex("wired_and", 2, 0, 4'b1000, 1'b1);
    step(3);
    ps2(8'hF0, 8'h3E);
    bus.joy = '0;
    ex("wired_rel", 2, 0, 4'hF, 1'b1);
    step(3);
    bus.sel_joy_n = 2'b11;
    bus.joy[5] = 1'b1;
    ex("fire2_joy", 1, 0, 4'hF, 1'b0);
    step(2);
    bus.joy = '0;
    step(2);
    // filtering and extended keys
    ps2(8'h00, 8'h16, 8'h00, 40'h1);
    ex("prnscr_ign", 2, 0, 4'hF, 1'b1);
    step(3);
    ps2(8'hE0, 8'h12);
    ex("e0_12_ign", 2, 0, 4'hF, 1'b1);
    step(3);
    ps2(8'h00, 8'h12);
    ex("fire2_kb", 2, 0, 4'hF, 1'b0);
    step(3);
    ps2(8'hF0, 8'h12);
    ex("fire2_rel", 2, 0, 4'hF, 1'b1);
    step(3);
    // keyboard never reaches port 1
    bus.sel_kp_n = 2'b01;
    ps2(8'h00, 8'h15);
    ex("p1_no_kb", 2, 1, 4'hF, 1'b1);
    step(3);
    ps2(8'hF0, 8'h15);
    step(3);
    // reset in the middle of a held key
    bus.sel_kp_n = 2'b10;
    ps2(8'h00, 8'h16);
    ex("pre_rst", 2, 0, 4'b1110, 1'b1);
    step(3);
    rst = 1'b1;
    ex("rst_mid", 1, 0, 4'hF, 1'b1);
    step(1);
    rst = 1'b0;
    ex("post_rst", 2, 0, 4'hF, 1'b1);
    step(3);
    // autofire on port 0 only
    bus.sel_kp_n = 2'b11;
    bus.sel_joy_n = 2'b00;
    bus.autofire_en = 2'b01;
    bus.joy = 32'h0010_0010;
    for (int i = 0; i < 12; i++) begin
`ifdef CV_PAD_AUTOFIRE_EN
      ex("af_p0", 1, 0, 4'hF, ((ne / 4) % 2) == 1);
`else
      ex("af_p0", 1, 0, 4'hF, 1'b0);
`endif
      ex("af_p1", 1, 1, 4'hF, 1'b0);
      step(1);
    end
    bus.joy = '0;
    step(3);
    chk("drain", 5'(q.size()), 5'd0);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule

// File: doc/cv_pad_encoder.md
Name: cv_pad_encoder

Overview:
- Parametrised ColecoVision controller encoder for NUM_PORTS ports.
- Merges the PS/2 keyboard (one port only) with per-port 16-bit MiSTer joystick words.
- Drives the console's strobe-selected pin lines p1-p4 and p6.
- Adds registered outputs, "last pressed wins" keypad arbitration and optional per-port autofire; sits between hps_io and cv_console.

Parameters:
- NUM_PORTS, 2, number of controller ports (1..4)
- KBD_PORT, 0, port index that receives keyboard state
- AF_HALF, 357954, clocks per autofire half-period (~15 Hz at 10.7 MHz effective rate)

Ports:
- clk_sys  in  1  system clock
- reset  in  1  synchronous, active-high reset
- ps2_key  in  66  hps_io key word: [64] toggle, [15:8] F0 break flag, [23:16]/[15:8] E0 extended flag, [7:0] scan code, [63:24] nonzero = PRNSCR/PAUSE
- joy  in  16*NUM_PORTS  joystick words; port p at [16p+15:16p], bit map: 0 R, 1 L, 2 D, 3 U, 4 fire1, 5 fire2(arm), 6 *, 7 #, 8..11 keys 0..3, 12 purple, 13 blue
- sel_kp_n  in  NUM_PORTS  keypad strobe (console p5 out), low = keypad selected
- sel_joy_n  in  NUM_PORTS  joystick strobe (console p8 out), low = joystick selected
- autofire_en  in  NUM_PORTS  per-port autofire request for fire1
- ctrl_d  out  4*NUM_PORTS  {p1,p2,p3,p4} for port p at [4p+3:4p], active low
- ctrl_p6  out  NUM_PORTS  fire line, active low

Behaviour:
- Reset: all key registers 0, keypad latch = NONE, ctrl_d = all 1s, ctrl_p6 = all 1s, AF counter 0, AF phase 1.
- PS/2 decode:
  - Register ps2_key[64]; an event fires when it differs from the registered copy.
  - Filtered code = 0 when [63:24] != 0.
  - pressed = ([15:8] != F0).
  - On an event, set or clear the mapped key register.
  - Map: arrows 75/72/6B/74; digits 16,1E,26,25,2E,36,3D,3E,46,45 (1-9,0); q w e a s d = 15 1D 24 1C 1B 23 (keys 4-9); z = *, x = 0, c = #; 1F/27 = purple; 11 = blue; 14 = fire1; non-extended 12/59 = fire2.
  - Unmapped codes are ignored.
- Merge: keyboard OR joy[KBD_PORT]. Other ports take their joystick only; keys 4-9 are 0 for them.
- Keypad vector per port, index 0..13 = 0,1,...,9,*,#,purple,blue.
- Keypad latch per port, updated every clock:
  - If any bit rose this cycle, latch = lowest rising index.
  - Else if the latched key was released, latch = lowest still-pressed index, or NONE.
  - Rise detection uses the previous-cycle vector, which is reset to 0.
- Codes (p1p2p3p4): 0=0011, 1=1110, 2=1101, 3=0110, 4=0001, 5=1001, 6=0111, 7=1100, 8=1000, 9=1011, *=1010, #=0101, purple=0100, blue=0010, NONE=1111.
- Output, registered with 1-cycle latency from inputs and latch:
  - kp = sel_kp_n ? 1111 : code(latch).
  - js = sel_joy_n ? 1111 : ~{U,D,L,R}.
  - ctrl_d = kp & js.
  - ctrl_p6 = (sel_kp_n | ~fire2) & (sel_joy_n | ~fire1eff).
- Both strobes low: outputs are ANDed (wired-AND emulation). Both high: 1111 / 1.
- Autofire counter: counts 0..AF_HALF-1 and wraps; the phase toggles on wrap.
- Reset asserted mid-operation overrides everything on the next edge. Held keys are not reasserted until a new PS/2 event or joystick level arrives.

Optional Feature:
- Macro CV_PAD_AUTOFIRE_EN.
- Defined: fire1eff = fire1 & (~autofire_en[p] | phase). Counter and phase registers are instantiated.
- Undefined: fire1eff = fire1. autofire_en is ignored, and no counter or phase logic is synthesised.

Test Plan:
- Reset, release -> ctrl_d = 1111 per port, ctrl_p6 = 1; after a PS/2 "16" make with sel_kp_n = 0 -> port0 ctrl_d = 1110 two cycles after the toggle.
- Hold joy key 1 (bit 9), then press x (45 make) -> code 0011; release x (F0 45) -> code returns to 1110; release all -> 1111.
- sel_joy_n = 0, sel_kp_n = 1, joy[1] = {U=1,R=1} (bits 3,0) -> port1 ctrl_d = 0110; joy[1] bit4 = 1 -> ctrl_p6[1] = 0.
- Both strobes low, key 8 (1000) plus joystick Left only (1101) -> ctrl_d = 1000; fire2 = 1 alone with sel_kp_n = 0 -> ctrl_p6 = 0.
- ps2_key[63:24] != 0 with toggle -> no key register changes; extended E0 12 make -> fire2 unchanged.
- With CV_PAD_AUTOFIRE_EN, AF_HALF = 4, autofire_en[0] = 1, fire1 held, sel_joy_n = 0 -> ctrl_p6[0] alternates 0/1 every 4 clocks. Without the macro -> ctrl_p6[0] = 0 steady.
